// File: rtl/iir_recursion_serial.sv
// Serial IIR pole section: y[n] = sat(round((x[n] - sum a_k*y[n-k]) >>> SHIFT)) on one shared multiplier.
// Optional sticky saturation flag output enabled by defining IIR_SAT_FLAG_EN.
module iir_recursion_serial #(
  parameter logic [83:0] COE   = {12'sd1, 12'sd13, 12'sd49, 12'sd189, 12'sd250, 12'sd609, 12'sd272},
  parameter int          SHIFT = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [25:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic signed [11:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef IIR_SAT_FLAG_EN
  ,
  output logic               sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, MAC, OUT_CALC, HOLD} state_t;

  localparam logic signed [27:0] RND = 28'sd1 <<< (SHIFT - 1);

  state_t             state, state_nxt;
  logic [2:0]         tap;
  logic signed [27:0] acc;
  logic signed [11:0] hist [0:6];
  logic signed [11:0] coef_sel;
  logic signed [11:0] hist_sel;
  logic signed [23:0] prod;
  logic signed [27:0] r_val;
  logic signed [11:0] y_val;
  logic               accept;

  function automatic logic signed [27:0] round_shift(input logic signed [27:0] a);
    logic signed [27:0] b;
    b = a + RND;
    return b >>> SHIFT;
  endfunction

  function automatic logic signed [11:0] sat12(input logic signed [27:0] v);
    if (v > 28'sd2047)
      return 12'sd2047;
    else if (v < -28'sd2048)
      return -12'sd2048;
    else
      return v[11:0];
  endfunction

  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Shared multiplier: tap k pairs a_{k+1} with y[n-1-k]
  always_comb begin
    coef_sel = COE[12*tap +: 12];
    hist_sel = hist[tap];
    prod     = coef_sel * hist_sel;
    r_val    = round_shift(acc);
    y_val    = sat12(r_val);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = MAC;
      MAC:      if (tap == 3'd6) state_nxt = OUT_CALC;
      OUT_CALC: state_nxt = HOLD;
      HOLD:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath; history advances on the output edge regardless of downstream readiness
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      tap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 7; i++) hist[i] <= '0;
`ifdef IIR_SAT_FLAG_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < 7; i++) hist[i] <= '0;
`ifdef IIR_SAT_FLAG_EN
            sat_flag <= 1'b0;
`endif
          end else if (in_valid) begin
            acc <= 28'(in_data);
            tap <= '0;
          end
        end
        MAC: begin
          acc <= acc - 28'(prod);
          tap <= (tap == 3'd6) ? 3'd0 : tap + 3'd1;
        end
        OUT_CALC: begin
          out_data  <= y_val;
          out_valid <= 1'b1;
          hist[0]   <= y_val;
          for (int i = 1; i < 7; i++) hist[i] <= hist[i-1];
`ifdef IIR_SAT_FLAG_EN
          if (r_val != 28'(y_val)) sat_flag <= 1'b1;
`endif
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
